// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with level flags, fill count and
// sticky overflow/underflow error flags.
module param_sync_fifo #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w,
    input  logic             r,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW + 1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;
    logic             ovf_evt;
    logic             unf_evt;

    // Flags decode only the registered count, never r or w.
    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_empty = (count <= AE_C);
    assign almost_full  = (count >= AF_C);

    // A read frees a slot in the same cycle, so a full FIFO still
    // accepts a write when a read is also accepted.
    assign wr_ok   = w && (!full || r);
    assign rd_ok   = r && !empty;
    assign ovf_evt = w && full && !r;
    assign unf_evt = r && empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem[rd_ptr];
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
            // A new error in the clearing cycle keeps the flag set.
            overflow  <= ovf_evt || (overflow && !clr_err);
            underflow <= unf_evt || (underflow && !clr_err);
        end
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_param_sync_fifo;

    logic        clk;
    logic        rst;
    logic        w;
    logic        r;
    logic        clr_err;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        empty;
    logic        full;
    logic        almost_empty;
    logic        almost_full;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int n_cmp = 0;
    int n_err = 0;

    int          q[$];
    logic [15:0] m_dout;
    logic        m_ovf;
    logic        m_unf;

    param_sync_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .w            (w),
        .r            (r),
        .clr_err      (clr_err),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words, 16 deep.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            bit is_full;
            bit is_empty;
            bit do_w;
            bit do_r;
            is_full  = (q.size() == 16);
            is_empty = (q.size() == 0);
            do_w = w && (!is_full || r);
            do_r = r && !is_empty;
            if (do_r) m_dout = 16'(q.pop_front());
            if (do_w) q.push_back(int'(data_in));
            if (w && is_full && !r) m_ovf = 1'b1;
            else if (clr_err) m_ovf = 1'b0;
            if (r && is_empty) m_unf = 1'b1;
            else if (clr_err) m_unf = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("m_count", 32'(count), 32'(q.size()));
        chk("m_empty", 32'(empty), 32'(q.size() == 0));
        chk("m_full", 32'(full), 32'(q.size() == 16));
        chk("m_ae", 32'(almost_empty), 32'(q.size() <= 2));
        chk("m_af", 32'(almost_full), 32'(q.size() >= 14));
        chk("m_dout", 32'(data_out), 32'(m_dout));
        chk("m_ovf", 32'(overflow), 32'(m_ovf));
        chk("m_unf", 32'(underflow), 32'(m_unf));
    end

    // Inputs change at a falling edge; the next rising edge applies them.
    task automatic step(input logic wi, input logic ri, input logic ci,
                        input logic [15:0] di);
        w       = wi;
        r       = ri;
        clr_err = ci;
        data_in = di;
        @(negedge clk);
        w       = 1'b0;
        r       = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        w       = 1'b0;
        r       = 1'b0;
        clr_err = 1'b0;
        data_in = '0;
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_dout", 32'(data_out), 0);
        @(negedge clk);
        rst = 1'b0;

        // Reads on empty
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0);
        chk("unf_set", 32'(underflow), 1);
        chk("unf_dout", 32'(data_out), 0);
        chk("unf_count", 32'(count), 0);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        chk("unf_clr", 32'(underflow), 0);

        // Fill
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'(i));
            chk("fill_count", 32'(count), 32'(i));
            if (i == 2) chk("ae_at2", 32'(almost_empty), 1);
            if (i == 3) chk("ae_at3", 32'(almost_empty), 0);
            if (i == 13) chk("af_at13", 32'(almost_full), 0);
            if (i == 14) chk("af_at14", 32'(almost_full), 1);
            if (i == 15) chk("full_at15", 32'(full), 0);
        end
        chk("full_at16", 32'(full), 1);

        // Overflow
        step(1'b1, 1'b0, 1'b0, 16'h8000);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        chk("ovf_clr", 32'(overflow), 0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0);
            chk("drain1", 32'(data_out), 32'(i));
        end
        chk("drain1_empty", 32'(empty), 1);

        // Simultaneous r/w while full, then drain across the wrap
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b0, 16'(i));
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'hA000 + 16'(i));
            chk("rw_full_dout", 32'(data_out), 32'(i));
            chk("rw_full_count", 32'(count), 16);
            chk("rw_full_ovf", 32'(overflow), 0);
        end
        for (int i = 5; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0);
            chk("drain2", 32'(data_out), 32'(i));
        end
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0);
            chk("drain2_wrap", 32'(data_out), 32'h0000_A000 + 32'(i));
        end

        // Simultaneous r/w while empty
        step(1'b1, 1'b1, 1'b0, 16'h1234);
        chk("rw_empty_count", 32'(count), 1);
        chk("rw_empty_unf", 32'(underflow), 1);
        chk("rw_empty_dout", 32'(data_out), 32'hA004);
        step(1'b0, 1'b1, 1'b1, 16'h0);
        chk("rw_empty_read", 32'(data_out), 32'h1234);
        chk("clr_vs_none", 32'(underflow), 0);

        // Clear and new error in the same cycle: error wins
        step(1'b0, 1'b1, 1'b1, 16'h0);
        chk("clr_vs_new", 32'(underflow), 1);
        step(1'b0, 1'b0, 1'b1, 16'h0);

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h5500 + 16'(i));
        chk("pre_rst_count", 32'(count), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_dout", 32'(data_out), 0);
        chk("arst_af", 32'(almost_full), 0);
        @(negedge clk);
        w       = 1'b1;
        r       = 1'b1;
        clr_err = 1'b1;
        data_in = 16'hDEAD;
        @(negedge clk);
        chk("rst_ignore_count", 32'(count), 0);
        w       = 1'b0;
        r       = 1'b0;
        clr_err = 1'b0;
        rst     = 1'b0;
        step(1'b0, 1'b1, 1'b0, 16'h0);
        chk("post_rst_unf", 32'(underflow), 1);
        step(1'b1, 1'b0, 1'b0, 16'hBEEF);
        step(1'b0, 1'b1, 1'b0, 16'h0);
        chk("post_rst_read", 32'(data_out), 32'hBEEF);
        chk("post_rst_empty", 32'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
